// File: rtl/chip8_sound_ctrl_if.sv
// chip8_sound_ctrl_if: CPU-side sound writes and the drive toward chip8_audio.
interface chip8_sound_ctrl_if;
    logic       st_wr_in;
    logic [7:0] st_data_in;
    logic       cfg_wr_in;
    logic [1:0] cfg_timbre_in;
    logic [9:0] cfg_tone_in;
    logic [2:0] cfg_vol_in;
    logic       tick_60_out;
    logic [7:0] st_out;
    logic       active_out;
    logic [1:0] timbre_out;
    logic [9:0] tone_out;
    logic [2:0] vol_out;

    modport master (
        output st_wr_in, st_data_in, cfg_wr_in, cfg_timbre_in, cfg_tone_in, cfg_vol_in,
        input  tick_60_out, st_out, active_out, timbre_out, tone_out, vol_out
    );

    modport slave (
        input  st_wr_in, st_data_in, cfg_wr_in, cfg_timbre_in, cfg_tone_in, cfg_vol_in,
        output tick_60_out, st_out, active_out, timbre_out, tone_out, vol_out
    );
endinterface

// File: rtl/chip8_sound_ctrl.sv
// chip8_sound_ctrl: CHIP-8 sound timer, 60 Hz tick and buzzer volume sequencer.
// Build option: define CHIP8_SOUND_RAMP_EN for the click-free attack/release volume ramp.
module chip8_sound_ctrl #(
`ifdef CHIP8_SOUND_RAMP_EN
    parameter int         RAMP_DIV   = 16_384,
`endif
    parameter int         TICK_DIV   = 1_237_500,
    parameter logic [1:0] DEF_TIMBRE = 2'd2,
    parameter logic [9:0] DEF_TONE   = 10'd750,
    parameter logic [2:0] DEF_VOL    = 3'd2
) (
    input logic               clk_in,
    input logic               rst_n_in,
    chip8_sound_ctrl_if.slave bus
);
    localparam int DW = $clog2(TICK_DIV);

`ifdef CHIP8_SOUND_RAMP_EN
    localparam int RW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;
    logic [RW-1:0] rc, rc_n;
    logic          expire;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SUSTAIN = 2'd2} state_t;
`endif

    state_t        state, state_n;
    logic [DW-1:0] div;
    logic          tick;
    logic [7:0]    st;
    logic [1:0]    timbre;
    logic [9:0]    tone;
    logic [2:0]    vol_t, vol, vol_n;

    assign tick = div == DW'(TICK_DIV - 1);

    // Free-running 60 Hz divider; CPU writes never disturb it.
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) div <= '0;
        else div <= tick ? '0 : div + 1'b1;

    // Sound timer: a CPU load beats a coincident tick, otherwise count down to 0.
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) st <= '0;
        else if (bus.st_wr_in) st <= bus.st_data_in;
        else if (tick && st != 8'd0) st <= st - 8'd1;

    // Sound configuration, loaded as one unit.
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) begin
            timbre <= DEF_TIMBRE;
            tone   <= DEF_TONE;
            vol_t  <= DEF_VOL;
        end else if (bus.cfg_wr_in) begin
            timbre <= bus.cfg_timbre_in;
            tone   <= bus.cfg_tone_in;
            vol_t  <= bus.cfg_vol_in;
        end

`ifdef CHIP8_SOUND_RAMP_EN
    assign expire = rc == RW'(RAMP_DIV - 1);

    // Envelope: ramp up toward the target, track it, ramp down to silence.
    always_comb begin
        state_n = state;
        vol_n   = vol;
        case (state)
            IDLE:    if (st != 8'd0) state_n = ATTACK;
            ATTACK:  if (st == 8'd0) state_n = RELEASE;
                     else if (vol >= vol_t) begin
                         vol_n   = vol_t;
                         state_n = SUSTAIN;
                     end else if (expire) vol_n = vol + 3'd1;
            SUSTAIN: begin
                         vol_n = vol_t;
                         if (st == 8'd0) state_n = RELEASE;
                     end
            RELEASE: if (st != 8'd0) state_n = ATTACK;
                     else if (vol == 3'd0) state_n = IDLE;
                     else if (expire) begin
                         vol_n = vol - 3'd1;
                         if (vol == 3'd1) state_n = IDLE;
                     end
            default: state_n = IDLE;
        endcase
        rc_n = (state_n != state || expire) ? '0 : rc + 1'b1;
    end

    // Envelope state, ramped volume and step timer.
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) begin
            state <= IDLE;
            vol   <= '0;
            rc    <= '0;
        end else begin
            state <= state_n;
            vol   <= vol_n;
            rc    <= rc_n;
        end
`else
    // Gate only: sound on whenever ST is running, volume jumps straight to target.
    always_comb begin
        state_n = st != 8'd0 ? SUSTAIN : IDLE;
        vol_n   = state_n == SUSTAIN ? vol_t : 3'd0;
    end

    // Gate state and output volume.
    always_ff @(posedge clk_in or negedge rst_n_in)
        if (!rst_n_in) begin
            state <= IDLE;
            vol   <= '0;
        end else begin
            state <= state_n;
            vol   <= vol_n;
        end
`endif

    assign bus.tick_60_out = tick;
    assign bus.st_out      = st;
    assign bus.active_out  = state != IDLE;
    assign bus.timbre_out  = timbre;
    assign bus.tone_out    = tone;
    assign bus.vol_out     = vol;
endmodule

// File: tb/tb_chip8_sound_ctrl.sv
// tb_chip8_sound_ctrl: scenario and randomized checks against a behavioural sound model.
module tb_chip8_sound_ctrl;
    localparam int TD = 10;
    localparam int RD = 4;
    localparam int P_IDLE = 0, P_ATT = 1, P_SUS = 2, P_REL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    int m_div, m_st, m_ph, m_vol, m_age, m_vt, m_timbre, m_tone;

    chip8_sound_ctrl_if bus();

    chip8_sound_ctrl #(
`ifdef CHIP8_SOUND_RAMP_EN
        .RAMP_DIV(RD),
`endif
        .TICK_DIV(TD)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_div = 0; m_st = 0; m_ph = P_IDLE; m_vol = 0; m_age = 0;
        m_vt = 2; m_timbre = 2; m_tone = 750;
    endtask

    // One clock edge of the sound behaviour, using the inputs presented for it.
    task automatic model_step();
        int ph = m_ph;
        int vol = m_vol;
        bit on = m_st != 0;
`ifdef CHIP8_SOUND_RAMP_EN
        bit step_due = (m_age % RD) == RD - 1;
        case (m_ph)
            P_IDLE: if (on) ph = P_ATT;
            P_ATT: begin
                if (!on) ph = P_REL;
                else if (m_vol >= m_vt) begin vol = m_vt; ph = P_SUS; end
                else if (step_due) vol = m_vol + 1;
            end
            P_SUS: begin vol = m_vt; if (!on) ph = P_REL; end
            default: begin
                if (on) ph = P_ATT;
                else if (m_vol == 0) ph = P_IDLE;
                else if (step_due) begin vol = m_vol - 1; if (vol == 0) ph = P_IDLE; end
            end
        endcase
`else
        ph = on ? P_SUS : P_IDLE;
        vol = on ? m_vt : 0;
`endif
        m_age = (ph != m_ph) ? 0 : m_age + 1;
        m_ph = ph;
        m_vol = vol;
        if (bus.st_wr_in) m_st = int'(bus.st_data_in);
        else if (m_div == TD - 1 && m_st > 0) m_st = m_st - 1;
        m_div = (m_div + 1) % TD;
        if (bus.cfg_wr_in) begin
            m_vt = int'(bus.cfg_vol_in); m_timbre = int'(bus.cfg_timbre_in); m_tone = int'(bus.cfg_tone_in);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        bus.st_wr_in = 1'b0;
        bus.cfg_wr_in = 1'b0;
    endtask

    task automatic drain();
        bus.st_data_in = 8'd0;
        bus.st_wr_in = 1'b1;
        step();
        for (int n = 0; n < 100 && m_ph != P_IDLE; n++) step();
    endtask

    task automatic test_reset();
        bus.st_wr_in = 0; bus.st_data_in = 0; bus.cfg_wr_in = 0;
        bus.cfg_timbre_in = 0; bus.cfg_tone_in = 0; bus.cfg_vol_in = 0;
        model_reset();
        #23;
        checks++;
        if (bus.active_out !== 1'b0 || bus.vol_out !== 3'd0 || bus.st_out !== 8'd0 || bus.tick_60_out !== 1'b0 ||
            bus.timbre_out !== 2'd2 || bus.tone_out !== 10'd750) begin
            failures++;
            $display("FAIL reset_values active=%b vol=%0d st=%0d tick=%b timbre=%0d tone=%0d want 0 0 0 0 2 750",
                     bus.active_out, bus.vol_out, bus.st_out, bus.tick_60_out, bus.timbre_out, bus.tone_out);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            checks++;
            if (bus.tick_60_out !== 1'(k % TD == TD - 1)) begin
                failures++;
                $display("FAIL tick_period cycle=%0d tick=%b want %b", k, bus.tick_60_out, k % TD == TD - 1);
            end
        end
    endtask

    task automatic test_note();
        int vcode, scode, n;
        bus.st_data_in = 8'd3;
        bus.st_wr_in = 1'b1;
        step();
        checks++;
        if (bus.st_out !== 8'd3 || bus.active_out !== 1'b0) begin
            failures++;
            $display("FAIL note_write st=%0d active=%b want 3 0", bus.st_out, bus.active_out);
        end
        vcode = int'(bus.vol_out) + 1;
        scode = int'(bus.st_out) + 1;
        step();
        checks++;
        if (bus.active_out !== 1'b1) begin
            failures++;
            $display("FAIL note_active_latency active=%b want 1", bus.active_out);
        end
        n = 0;
        do begin
            if (int'(bus.vol_out) + 1 != vcode % 10) vcode = vcode * 10 + int'(bus.vol_out) + 1;
            if (int'(bus.st_out) + 1 != scode % 10) scode = scode * 10 + int'(bus.st_out) + 1;
            checks++;
            if (bus.st_out !== 8'(m_st) || bus.vol_out !== 3'(m_vol) || bus.active_out !== 1'(m_ph != P_IDLE)) begin
                failures++;
                $display("FAIL note_cycle n=%0d st=%0d vol=%0d active=%b want %0d %0d %b",
                         n, bus.st_out, bus.vol_out, bus.active_out, m_st, m_vol, m_ph != P_IDLE);
            end
            if (m_ph == P_IDLE) break;
            step();
            n++;
        end while (n < 200);
        checks++;
        if (n >= 200 || bus.active_out !== 1'b0) begin
            failures++;
            $display("FAIL note_end cycles=%0d active=%b want idle", n, bus.active_out);
        end
        checks++;
        if (scode != 4321) begin
            failures++;
            $display("FAIL note_st_seq code=%0d want 4321", scode);
        end
        checks++;
`ifdef CHIP8_SOUND_RAMP_EN
        if (vcode != 12321) begin
            failures++;
            $display("FAIL note_vol_seq code=%0d want 12321", vcode);
        end
`else
        if (vcode != 131) begin
            failures++;
            $display("FAIL note_vol_seq code=%0d want 131", vcode);
        end
`endif
    endtask

    task automatic test_write_on_tick();
        int n = 0;
        bus.st_data_in = 8'd2;
        bus.st_wr_in = 1'b1;
        step();
        while (m_div != TD - 1 && n < 30) begin step(); n++; end
        checks++;
        if (bus.tick_60_out !== 1'b1 || bus.st_out !== 8'd2) begin
            failures++;
            $display("FAIL tickwr_setup tick=%b st=%0d want 1 2", bus.tick_60_out, bus.st_out);
        end
        bus.st_data_in = 8'd5;
        bus.st_wr_in = 1'b1;
        step();
        checks++;
        if (bus.st_out !== 8'd5) begin
            failures++;
            $display("FAIL tickwr_value st=%0d want 5", bus.st_out);
        end
        drain();
    endtask

    task automatic test_retrigger();
`ifdef CHIP8_SOUND_RAMP_EN
        int n = 0;
        bus.st_data_in = 8'd2;
        bus.st_wr_in = 1'b1;
        step();
        while (!(m_ph == P_REL && m_vol == 1) && n < 100) begin step(); n++; end
        checks++;
        if (n >= 100 || bus.vol_out !== 3'd1 || bus.active_out !== 1'b1) begin
            failures++;
            $display("FAIL retrig_reach cycles=%0d vol=%0d active=%b want release at 1", n, bus.vol_out, bus.active_out);
        end
        bus.st_data_in = 8'd4;
        bus.st_wr_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (bus.active_out !== 1'b1 || bus.vol_out === 3'd0 || bus.vol_out !== 3'(m_vol)) begin
                failures++;
                $display("FAIL retrig_cycle k=%0d vol=%0d active=%b want %0d 1", k, bus.vol_out, bus.active_out, m_vol);
            end
        end
        checks++;
        if (bus.vol_out !== 3'd2) begin
            failures++;
            $display("FAIL retrig_final vol=%0d want 2", bus.vol_out);
        end
        drain();
`endif
    endtask

    task automatic test_cfg();
        int n = 0;
        bus.st_data_in = 8'd60;
        bus.st_wr_in = 1'b1;
        step();
        while (m_ph != P_SUS && n < 50) begin step(); n++; end
        bus.cfg_vol_in = 3'd7; bus.cfg_tone_in = 10'd300; bus.cfg_timbre_in = 2'd1;
        bus.cfg_wr_in = 1'b1;
        step();
        checks++;
        if (bus.tone_out !== 10'd300 || bus.timbre_out !== 2'd1 || bus.vol_out !== 3'd2 || bus.active_out !== 1'b1) begin
            failures++;
            $display("FAIL cfg_immediate tone=%0d timbre=%0d vol=%0d active=%b want 300 1 2 1",
                     bus.tone_out, bus.timbre_out, bus.vol_out, bus.active_out);
        end
        step();
        checks++;
        if (bus.vol_out !== 3'd7) begin
            failures++;
            $display("FAIL cfg_vol_follow vol=%0d want 7", bus.vol_out);
        end
        bus.cfg_vol_in = 3'd0;
        bus.cfg_wr_in = 1'b1;
        step();
        step();
        checks++;
        if (bus.vol_out !== 3'd0 || bus.active_out !== 1'b1) begin
            failures++;
            $display("FAIL cfg_vol_zero vol=%0d active=%b want 0 1", bus.vol_out, bus.active_out);
        end
        bus.cfg_vol_in = 3'd2; bus.cfg_tone_in = 10'd750; bus.cfg_timbre_in = 2'd2;
        bus.cfg_wr_in = 1'b1;
        step();
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                bus.st_data_in = 8'($urandom_range(0, 6));
                bus.st_wr_in = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) begin
                bus.cfg_vol_in = 3'($urandom_range(0, 7));
                bus.cfg_tone_in = 10'($urandom_range(0, 1023));
                bus.cfg_timbre_in = 2'($urandom_range(0, 3));
                bus.cfg_wr_in = 1'b1;
            end
            step();
            checks++;
            if (bus.st_out !== 8'(m_st) || bus.vol_out !== 3'(m_vol) || bus.active_out !== 1'(m_ph != P_IDLE) ||
                bus.tick_60_out !== 1'(m_div == TD - 1) || bus.timbre_out !== 2'(m_timbre) || bus.tone_out !== 10'(m_tone)) begin
                failures++;
                $display("FAIL random k=%0d st=%0d vol=%0d act=%b tick=%b timbre=%0d tone=%0d want %0d %0d %b %b %0d %0d",
                         k, bus.st_out, bus.vol_out, bus.active_out, bus.tick_60_out, bus.timbre_out, bus.tone_out,
                         m_st, m_vol, m_ph != P_IDLE, m_div == TD - 1, m_timbre, m_tone);
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        int n = 0;
        bus.cfg_vol_in = 3'd5; bus.cfg_tone_in = 10'd100; bus.cfg_timbre_in = 2'd3;
        bus.cfg_wr_in = 1'b1;
        bus.st_data_in = 8'd40;
        bus.st_wr_in = 1'b1;
        step();
        while (m_vol < 1 && n < 50) begin step(); n++; end
        checks++;
        if (bus.active_out !== 1'b1 || bus.vol_out === 3'd0) begin
            failures++;
            $display("FAIL areset_setup active=%b vol=%0d want sounding", bus.active_out, bus.vol_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.active_out !== 1'b0 || bus.vol_out !== 3'd0 || bus.st_out !== 8'd0 || bus.tick_60_out !== 1'b0 ||
            bus.timbre_out !== 2'd2 || bus.tone_out !== 10'd750) begin
            failures++;
            $display("FAIL areset_values active=%b vol=%0d st=%0d tick=%b timbre=%0d tone=%0d want 0 0 0 0 2 750",
                     bus.active_out, bus.vol_out, bus.st_out, bus.tick_60_out, bus.timbre_out, bus.tone_out);
        end
        model_reset();
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            checks++;
            if (bus.st_out !== 8'(m_st) || bus.vol_out !== 3'(m_vol) || bus.active_out !== 1'(m_ph != P_IDLE) ||
                bus.tick_60_out !== 1'(m_div == TD - 1)) begin
                failures++;
                $display("FAIL areset_after k=%0d st=%0d vol=%0d act=%b tick=%b want %0d %0d %b %b", k, bus.st_out,
                         bus.vol_out, bus.active_out, bus.tick_60_out, m_st, m_vol, m_ph != P_IDLE, m_div == TD - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_note();
        test_write_on_tick();
        test_retrigger();
        test_cfg();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/chip8_sound_ctrl.md
# chip8_sound_ctrl

Sequencer for the CHIP-8 buzzer: it owns the 8-bit sound timer (ST), generates the 60 Hz timer tick, latches the sound configuration written by the CPU, and drives `chip8_audio`'s `active_in`, `timbre_in`, `tone_in` and `vol_in`. It sits between the CPU execute stage (FX18 writes and the config register writes) and the audio datapath. A volume ramp shapes note on/off to avoid clicks.

## Interface
- `TICK_DIV`, 1_237_500: clock cycles per 60 Hz tick (74.25 MHz / 60); minimum 2.
- `RAMP_DIV`, 16_384: cycles per one-step volume change during attack and release; minimum 1.
- `DEF_TIMBRE`, 2: reset value of the timbre register.
- `DEF_TONE`, 750: reset value of the tone register.
- `DEF_VOL`, 2: reset value of the target volume register.
- `clk_in`  in  1  system clock.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `st_wr_in`  in  1  one-cycle strobe that loads ST (FX18).
- `st_data_in`  in  8  ST load value.
- `cfg_wr_in`  in  1  one-cycle strobe that loads timbre, tone and target volume together.
- `cfg_timbre_in`  in  2  timbre value to load.
- `cfg_tone_in`  in  10  tone value to load.
- `cfg_vol_in`  in  3  target volume value to load.
- `tick_60_out`  out  1  one-cycle pulse at 60 Hz; shared with the delay timer.
- `st_out`  out  8  current ST value.
- `active_out`  out  1  to `chip8_audio.active_in`.
- `timbre_out`  out  2  to `chip8_audio.timbre_in`.
- `tone_out`  out  10  to `chip8_audio.tone_in`.
- `vol_out`  out  3  to `chip8_audio.vol_in`; the ramped volume.

## Operation
- Divider: counts 0..TICK_DIV-1 and wraps. `tick_60_out` = 1 while count == TICK_DIV-1. Never cleared by writes.
- ST: on a tick, ST decrements if nonzero and holds at 0. `st_wr_in` loads `st_data_in`. If a write and a tick fall in the same cycle, the write wins and there is no decrement. Writing 0 stops the sound.
- Config: `cfg_wr_in` loads all three registers. `timbre_out` and `tone_out` are the registers directly, so changes take effect immediately. The volume register is the target (`vol_t`).
- FSM states: IDLE, ATTACK, SUSTAIN, RELEASE.
  - `active_out` = (state != IDLE).
  - `vol_out` is a 3-bit register, clamped to 0..7; it never wraps.
- FSM transitions:
  - IDLE: if ST != 0, go to ATTACK and clear the ramp counter.
  - ATTACK: if ST == 0, go to RELEASE. Otherwise, each time the ramp counter expires, `vol_out`++. When `vol_out` >= `vol_t`, set `vol_out` = `vol_t` and go to SUSTAIN; this includes `vol_t` = 0, which takes one cycle.
  - SUSTAIN: `vol_out` follows `vol_t` every cycle. If ST == 0, go to RELEASE.
  - RELEASE: if ST != 0, go to ATTACK and keep the current `vol_out`. Otherwise, each time the ramp counter expires, `vol_out`--. The step 1 -> 0 and the move to IDLE happen on the same edge. Entering RELEASE with `vol_out` = 0 goes to IDLE on the next edge.
- Ramp counter: cleared on every state change; expires when it reaches RAMP_DIV-1.

## Timing
- Reset values (async assert, sync release): divider 0, ST 0, state IDLE, `vol_out` 0, `active_out` 0, `tick_60_out` 0, `timbre_out` DEF_TIMBRE, `tone_out` DEF_TONE, `vol_t` DEF_VOL.
- Reset mid-note: outputs drop at once and there is no release ramp.
- First tick: the first `tick_60_out` occurs TICK_DIV-1 cycles after reset release.
- Write latency: `st_wr_in` sampled at edge N gives `st_out` valid after N and `active_out` = 1 after N+1.
- First volume step: the first `vol_out` increment comes RAMP_DIV cycles after ATTACK entry.
- Stop latency: ST reaches 0 at edge N, state is RELEASE after N+1, and `active_out` stays 1 until `vol_out` returns to 0.
- Config latency: `cfg_wr_in` at edge N makes outputs and `vol_t` valid after N. In SUSTAIN, `vol_out` updates after N+1.

## Configuration
- Macro `CHIP8_SOUND_RAMP_EN`, ramp on:
  - Behaviour is as described in Operation.
  - RAMP_DIV and the ramp counter exist.
- Macro `CHIP8_SOUND_RAMP_EN` undefined, ramp off:
  - ATTACK and RELEASE are removed.
  - IDLE goes to SUSTAIN when ST != 0, and SUSTAIN goes to IDLE when ST == 0.
  - `vol_out` = 0 in IDLE and `vol_t` in SUSTAIN.
  - Latency to `active_out` is unchanged.

## Test plan
Parameters for all scenarios: TICK_DIV=10, RAMP_DIV=4, default config.
- Reset release → `tick_60_out` pulses every 10 cycles; `timbre_out`=2, `tone_out`=750, `vol_out`=0, `active_out`=0.
- `st_wr_in` with 3 → `st_out` goes 3,2,1,0 on successive ticks. `active_out` rises 2 cycles after the write. `vol_out` goes 0→1→2 at 4-cycle steps. SUSTAIN holds `vol_out` at 2. RELEASE steps 2→1→0, then IDLE and `active_out`=0.
- `st_wr_in` with 5 on the same cycle as a tick → `st_out`=5, with no decrement on that cycle.
- During RELEASE at `vol_out`=1, write ST=4 → state goes to ATTACK with no glitch to 0; `vol_out` climbs back to 2 and `active_out` stays 1.
- In SUSTAIN, `cfg_wr_in` with vol 7, tone 300, timbre 1 → `tone_out`=300 and `timbre_out`=1 next cycle; `vol_out`=7 one cycle later. Writing vol 0 gives `vol_out`=0 with `active_out` still 1.
- Assert `rst_n_in` low mid-ATTACK → all outputs reach their reset values immediately, asynchronously, without waiting for a clock edge. With `CHIP8_SOUND_RAMP_EN` undefined, rerun scenario 2: `vol_out` jumps 0→2→0.
